// File: rtl/frame_ram_arbiter.sv
// Arbitrates one single-port frame RAM between a buffered write stream and a
// latency-critical reader; reads win unless a write has been starved or the FIFO is full.
module frame_ram_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int RAM_LATENCY     = 1,
  parameter int MAX_READ_STREAK = 4
) (
  input  logic                            clk_33,
  input  logic                            rst,
  input  logic                            wr_valid,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ready,
  input  logic                            rd_req,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic                            rd_grant,
  output logic                            rd_valid,
  output logic [DATA_W-1:0]               rd_data,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  output logic                            ram_we,
  input  logic [DATA_W-1:0]               ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_READ  = 2'd1;
  localparam logic [1:0] GNT_WRITE = 2'd2;

  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [STREAK_W-1:0] streak;
  logic [1:0]          decision;
  logic                fifo_nonempty;
  logic                fifo_full;
  logic                force_write;
  logic                do_push;
  logic                do_pop;
  logic [RAM_LATENCY:0] rd_pipe;

  // Handshakes: a write transfers on any cycle where wr_valid && wr_ready;
  // a read transfers on any cycle where rd_req && rd_grant, and the requester
  // holds rd_req/rd_addr stable until that cycle.
  assign fifo_nonempty = (level != '0);
  assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
  assign wr_ready      = !fifo_full;
  assign fifo_level    = level;
  assign force_write   = fifo_nonempty &&
                         ((streak == STREAK_W'(MAX_READ_STREAK)) || fifo_full);

  always_comb begin
    decision = GNT_IDLE;
    if (force_write)        decision = GNT_WRITE;
    else if (rd_req)        decision = GNT_READ;
    else if (fifo_nonempty) decision = GNT_WRITE;
  end

  assign rd_grant = (decision == GNT_READ);
  assign do_pop   = (decision == GNT_WRITE);
  assign do_push  = wr_valid && wr_ready;

  // Storage has no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk_33) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_33 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_33 or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (do_pop || !fifo_nonempty) begin
      streak <= '0;
    end else if (rd_grant && (streak != STREAK_W'(MAX_READ_STREAK))) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk_33 or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      ram_we <= do_pop;
      if (do_pop) begin
        ram_addr  <= fifo_addr[rd_ptr];
        ram_wdata <= fifo_data[rd_ptr];
      end else if (rd_grant) begin
        ram_addr <= rd_addr;
      end
    end
  end

  // rd_pipe[RAM_LATENCY] is high in the cycle the granted read's data sits on ram_rdata.
  always_ff @(posedge clk_33 or posedge rst) begin
    if (rst) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[RAM_LATENCY-1:0], rd_grant};
      rd_valid <= rd_pipe[RAM_LATENCY];
      if (rd_pipe[RAM_LATENCY]) rd_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a latency-1 behavioural RAM and a
// negedge log of every RAM write.
module tb_frame_ram_arbiter;

  logic        clk_33 = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_grant;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [31:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = 16'h0;
  logic [3:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [logic [31:0]];
  logic [47:0] wlog [$];

  frame_ram_arbiter dut (
    .clk_33(clk_33), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .fifo_level(fifo_level)
  );

  always #15 clk_33 = ~clk_33;

  // Unwritten locations read back as addr ^ 0xFFFF.
  always @(posedge clk_33) begin
    if (ram_we) mem[ram_addr] = ram_wdata;
    ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : (ram_addr[15:0] ^ 16'hFFFF);
  end

  always @(negedge clk_33) begin
    if (ram_we) wlog.push_back({ram_addr, ram_wdata});
  end

  task automatic tick();
    @(posedge clk_33);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] exp4_g;
  logic [11:0] exp4_we;
  logic [11:0] exp5_g;
  logic [11:0] exp5_r;
  int          exp5_l [12];
  int          k;

  initial begin
    exp4_g  = 12'b1011_1101_1111;
    exp4_we = 12'b1000_0100_0000;
    exp5_g  = 12'b0101_1101_1111;
    exp5_r  = 12'b0101_1111_1111;
    exp5_l  = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 8, 7, 8};

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) tick();
    #1;
    chk("rst_ram_we", 48'(ram_we), 48'h0);
    chk("rst_ram_addr", 48'(ram_addr), 48'h0);
    chk("rst_ram_wdata", 48'(ram_wdata), 48'h0);
    chk("rst_rd_valid", 48'(rd_valid), 48'h0);
    chk("rst_rd_data", 48'(rd_data), 48'h0);
    chk("rst_level", 48'(fifo_level), 48'h0);
    rst = 1'b0;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("idle_ram_we", 48'(ram_we), 48'h0);
      chk("idle_rd_grant", 48'(rd_grant), 48'h0);
      chk("idle_rd_valid", 48'(rd_valid), 48'h0);
      chk("idle_wr_ready", 48'(wr_ready), 48'h1);
      chk("idle_level", 48'(fifo_level), 48'h0);
    end

    // Single read of 0x10
    tick(); rd_req = 1'b1; rd_addr = 32'h10; #1;
    chk("rd1_grant", 48'(rd_grant), 48'h1);
    tick(); rd_req = 1'b0; #1;
    chk("rd1_ram_addr", 48'(ram_addr), 48'h10);
    chk("rd1_ram_we", 48'(ram_we), 48'h0);
    chk("rd1_valid_n1", 48'(rd_valid), 48'h0);
    chk("rd1_grant_off", 48'(rd_grant), 48'h0);
    tick(); #1;
    chk("rd1_valid_n2", 48'(rd_valid), 48'h0);
    chk("rd1_addr_hold", 48'(ram_addr), 48'h10);
    tick(); #1;
    chk("rd1_valid_n3", 48'(rd_valid), 48'h1);
    chk("rd1_data", 48'(rd_data), 48'hFFEF);
    tick(); #1;
    chk("rd1_valid_n4", 48'(rd_valid), 48'h0);
    chk("rd1_data_hold", 48'(rd_data), 48'hFFEF);

    // Three writes, no reads
    tick(); wr_valid = 1'b1; wr_addr = 32'h0; wr_data = 16'hAAAA; #1;
    chk("w3_ready", 48'(wr_ready), 48'h1);
    chk("w3_level0", 48'(fifo_level), 48'h0);
    tick(); wr_addr = 32'h1; wr_data = 16'hBBBB; #1;
    chk("w3_level1", 48'(fifo_level), 48'h1);
    chk("w3_we0", 48'(ram_we), 48'h0);
    tick(); wr_addr = 32'h2; wr_data = 16'hCCCC; #1;
    chk("w3_level2", 48'(fifo_level), 48'h1);
    chk("w3_wr_a", {ram_addr, ram_wdata, 15'h0, ram_we}, {32'h0, 16'hAAAA, 16'h1});
    tick(); wr_valid = 1'b0; #1;
    chk("w3_level3", 48'(fifo_level), 48'h1);
    chk("w3_wr_b", {ram_addr, ram_wdata, 15'h0, ram_we}, {32'h1, 16'hBBBB, 16'h1});
    tick(); #1;
    chk("w3_level4", 48'(fifo_level), 48'h0);
    chk("w3_wr_c", {ram_addr, ram_wdata, 15'h0, ram_we}, {32'h2, 16'hCCCC, 16'h1});
    tick(); #1;
    chk("w3_we_end", 48'(ram_we), 48'h0);
    chk("w3_level_end", 48'(fifo_level), 48'h0);

    // Read streak limit with two writes queued
    for (int i = 0; i < 12; i++) begin
      tick();
      rd_req = 1'b1; rd_addr = 32'h100 + 32'(i);
      if (i == 0) begin wr_valid = 1'b1; wr_addr = 32'h20; wr_data = 16'h1111; end
      else if (i == 1) begin wr_valid = 1'b1; wr_addr = 32'h21; wr_data = 16'h2222; end
      else wr_valid = 1'b0;
      #1;
      chk($sformatf("streak_grant_%0d", i), 48'(rd_grant), 48'(exp4_g[i]));
      chk($sformatf("streak_we_%0d", i), 48'(ram_we), 48'(exp4_we[i]));
      if (i == 6) chk("streak_wr0", {ram_addr, ram_wdata}, {32'h20, 16'h1111});
      if (i == 11) begin
        chk("streak_wr1", {ram_addr, ram_wdata}, {32'h21, 16'h2222});
        chk("streak_level", 48'(fifo_level), 48'h0);
      end
    end
    tick(); rd_req = 1'b0;
    repeat (5) tick();

    // FIFO fill under continuous reads
    wlog.delete();
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      rd_req = 1'b1; rd_addr = 32'h200 + 32'(i);
      wr_valid = 1'b1; wr_addr = 32'h40 + 32'(k); wr_data = 16'h5000 + 16'(k);
      #1;
      chk($sformatf("fill_grant_%0d", i), 48'(rd_grant), 48'(exp5_g[i]));
      chk($sformatf("fill_ready_%0d", i), 48'(wr_ready), 48'(exp5_r[i]));
      chk($sformatf("fill_level_%0d", i), 48'(fifo_level), 48'(exp5_l[i]));
      if (wr_ready) k++;
    end
    tick(); wr_valid = 1'b0; rd_req = 1'b0; #1;
    chk("fill_level_after", 48'(fifo_level), 48'h7);
    repeat (10) tick();
    chk("fill_level_drained", 48'(fifo_level), 48'h0);
    chk("fill_accepted", 48'(k), 48'd10);
    chk("fill_wlog_size", 48'(wlog.size()), 48'd10);
    for (int j = 0; j < 10; j++) begin
      if (j < wlog.size())
        chk($sformatf("fill_wr_%0d", j), wlog[j], {32'h40 + 32'(j), 16'h5000 + 16'(j)});
    end

    // Reset with reads in flight and writes queued
    for (int i = 0; i < 5; i++) begin
      tick();
      rd_req = 1'b1; rd_addr = 32'h60 + 32'(i);
      wr_valid = 1'b1; wr_addr = 32'h80 + 32'(i); wr_data = 16'h9000 + 16'(i);
    end
    tick(); #1;
    chk("pre_rst_level", 48'(fifo_level), 48'h5);
    rst = 1'b1; rd_req = 1'b0; wr_valid = 1'b0; #1;
    chk("mid_rst_level", 48'(fifo_level), 48'h0);
    chk("mid_rst_we", 48'(ram_we), 48'h0);
    chk("mid_rst_valid", 48'(rd_valid), 48'h0);
    tick(); rst = 1'b0; wlog.delete(); #1;
    chk("post_rst_level", 48'(fifo_level), 48'h0);
    chk("post_rst_ready", 48'(wr_ready), 48'h1);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk($sformatf("post_rst_valid_%0d", i), 48'(rd_valid), 48'h0);
      chk($sformatf("post_rst_we_%0d", i), 48'(ram_we), 48'h0);
    end

    // Normal operation resumes
    tick(); rd_req = 1'b1; rd_addr = 32'h33; #1;
    chk("resume_grant", 48'(rd_grant), 48'h1);
    tick(); rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 32'h7; wr_data = 16'h1234; #1;
    chk("resume_ram_addr", 48'(ram_addr), 48'h33);
    chk("resume_ram_we0", 48'(ram_we), 48'h0);
    tick(); wr_valid = 1'b0; #1;
    chk("resume_valid0", 48'(rd_valid), 48'h0);
    chk("resume_level", 48'(fifo_level), 48'h1);
    tick(); #1;
    chk("resume_valid", 48'(rd_valid), 48'h1);
    chk("resume_data", 48'(rd_data), 48'hFFCC);
    chk("resume_wr", {ram_addr, ram_wdata, 15'h0, ram_we}, {32'h7, 16'h1234, 16'h1});
    tick(); #1;
    chk("resume_wlog_size", 48'(wlog.size()), 48'd1);
    if (wlog.size() > 0) chk("resume_wlog0", wlog[0], {32'h7, 16'h1234});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
